aq_memcpy_cmd_arb: RTL and testbench

Round-robin command arbiter that shares a single memcpy engine command port (CMD_REQ/CMD_READY/CMD_DONE, CMD_DST/SRC/LEN) among NREQ requesters. It sits between the requesters and the AXI memcpy engine, latches one requester's descriptor, issues it, and tracks completion. Completion is routed back to the owning requester. Only one copy is outstanding at a time.

---
 rtl/aq_memcpy_cmd_arb.sv | 205 ++++++++++++++++++++
 tb/tb_aq_memcpy_cmd_arb.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_memcpy_cmd_arb.sv
// aq_memcpy_cmd_arb
// Round-robin arbiter that shares one memcpy engine command port among NREQ
// requesters. In IDLE it picks a requester, latches that requester's
// descriptor, issues it to the engine, waits for completion and then routes
// the completion back to the owner. Only one copy is outstanding at a time.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[NREQ]       per-requester request level, held until req_ack
//   req_dst/src/len       32-bit descriptor fields, requester i at [32i+31:32i]
//   req_ack[NREQ]         one-cycle pulse when the descriptor is latched
//   req_done[NREQ]        one-cycle pulse when the copy has completed
//   req_err[NREQ]         one-cycle pulse on watchdog abort (0 without the macro)
//   cmd_req               issue strobe to the engine, held until cmd_ready
//   cmd_ready, cmd_done   engine idle/accept, engine completion pulse
//   cmd_dst/src/len       latched descriptor, stable from one ack to the next
//   busy                  high in every state except IDLE
//   owner                 index of the current or last granted requester
//
// Optional feature: define AQ_MEMCPY_ARB_TIMEOUT_EN to enable a watchdog that
// aborts a command after TIMEOUT cycles in ISSUE/WAIT and pulses req_err.
// Without the macro, WAIT waits indefinitely for cmd_done.

module aq_memcpy_cmd_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_dst,
    input  logic [32*NREQ-1:0]   req_src,
    input  logic [32*NREQ-1:0]   req_len,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic                 cmd_req,
    input  logic                 cmd_ready,
    input  logic                 cmd_done,
    output logic [31:0]          cmd_dst,
    output logic [31:0]          cmd_src,
    output logic [31:0]          cmd_len,
    output logic                 busy,
    output logic [2:0]           owner
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIN} state_t;

    state_t            state, state_next;
    logic [2:0]        ptr, ptr_next;
    logic              found, grant, timeout_hit;
    int                win_idx, cand;
    logic [NREQ-1:0]   rv_rot, win_mask, owner_mask;
    logic [NREQ-1:0]   ack_next, done_next, err_next;
    logic              cmd_req_next;
    logic [32*NREQ-1:0] dst_sh, src_sh, len_sh;
    logic [31:0]       dst_sel, src_sel, len_sel;

    // Winner search: first set request starting just above the last owner,
    // wrapping, so the most recently served requester has lowest priority.
    always_comb begin
        // NOTE: every variable gets a default before any branch so the
        // combinational block can never infer a latch.
        found   = 1'b0;
        win_idx = 0;
        cand    = 0;
        rv_rot  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand   = (int'(ptr) + k) % NREQ;
            rv_rot = req_valid >> cand;
            if (!found && rv_rot[0]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Shifts rather than variable part-selects keep index widths exact.
    assign dst_sh     = req_dst >> (32 * win_idx);
    assign src_sh     = req_src >> (32 * win_idx);
    assign len_sh     = req_len >> (32 * win_idx);
    assign dst_sel    = dst_sh[31:0];
    assign src_sel    = src_sh[31:0];
    assign len_sel    = len_sh[31:0];
    assign win_mask   = NREQ'(1) << win_idx;
    assign owner_mask = NREQ'(1) << owner;

`ifdef AQ_MEMCPY_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt;

    // Cleared on every grant (the only way into ISSUE), counts while a
    // command is in flight. The >= keeps the abort armed if ISSUE handed a
    // command to WAIT in the very cycle the limit was reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (grant) begin
            wd_cnt <= '0;
        end else if (state == S_ISSUE || state == S_WAIT) begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end

    assign timeout_hit = (state == S_ISSUE || state == S_WAIT) &&
                         (wd_cnt >= 32'(TIMEOUT - 1));
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic and next values of the registered output pulses.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        grant        = 1'b0;
        ack_next     = '0;
        done_next    = '0;
        err_next     = '0;
        cmd_req_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (found && cmd_ready) begin
                    grant    = 1'b1;
                    ack_next = win_mask;
                    if (len_sel == 32'd0) begin
                        state_next = S_FIN;
                    end else begin
                        state_next   = S_ISSUE;
                        cmd_req_next = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                // An accepted command always proceeds to WAIT so the engine
                // is never left with an orphaned copy.
                if (cmd_ready) begin
                    state_next = S_WAIT;
                end else if (timeout_hit) begin
                    err_next   = owner_mask;
                    ptr_next   = owner;
                    state_next = S_IDLE;
                end else begin
                    cmd_req_next = 1'b1;
                end
            end
            S_WAIT: begin
                // A completion coinciding with the watchdog wins.
                if (cmd_done) begin
                    state_next = S_FIN;
                end else if (timeout_hit) begin
                    err_next   = owner_mask;
                    ptr_next   = owner;
                    state_next = S_IDLE;
                end
            end
            S_FIN: begin
                done_next  = owner_mask;
                ptr_next   = owner;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control state and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= 3'(NREQ - 1);
            req_ack  <= '0;
            req_done <= '0;
            req_err  <= '0;
            cmd_req  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state    <= state_next;
            ptr      <= ptr_next;
            req_ack  <= ack_next;
            req_done <= done_next;
            req_err  <= err_next;
            cmd_req  <= cmd_req_next;
            busy     <= (state_next != S_IDLE);
        end
    end

    // Descriptor latch: loads only on a grant and holds until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are plain registers, not memory, so they take the
            // asynchronous reset like the rest of the state.
            cmd_dst <= '0;
            cmd_src <= '0;
            cmd_len <= '0;
            owner   <= '0;
        end else if (grant) begin
            cmd_dst <= dst_sel;
            cmd_src <= src_sel;
            cmd_len <= len_sel;
            owner   <= 3'(win_idx);
        end
    end

endmodule

// File: tb/tb_aq_memcpy_cmd_arb.sv
// Directed testbench for aq_memcpy_cmd_arb (NREQ=4, TIMEOUT=20).
// Inputs are driven and outputs observed 1 ns after each rising edge; the
// value seen at that point is the registered output for the current cycle.
// Handshake timing expected here: ack in the cycle after the request is
// sampled, cmd_req in the same cycle as ack, FIN in the cycle after cmd_done
// is sampled, and req_done in the cycle after FIN (so a zero-length request
// shows ack at n+1 and done at n+2).

module tb_aq_memcpy_cmd_arb;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [127:0]  req_dst, req_src, req_len;
    logic [3:0]    req_ack, req_done, req_err;
    logic          cmd_req, cmd_ready, cmd_done;
    logic [31:0]   cmd_dst, cmd_src, cmd_len;
    logic          busy;
    logic [2:0]    owner;

    int total = 0;
    int bad   = 0;

    aq_memcpy_cmd_arb #(.NREQ(4), .TIMEOUT(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_dst   (req_dst),
        .req_src   (req_src),
        .req_len   (req_len),
        .req_ack   (req_ack),
        .req_done  (req_done),
        .req_err   (req_err),
        .cmd_req   (cmd_req),
        .cmd_ready (cmd_ready),
        .cmd_done  (cmd_done),
        .cmd_dst   (cmd_dst),
        .cmd_src   (cmd_src),
        .cmd_len   (cmd_len),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int i, input logic [31:0] d, input logic [31:0] s,
                            input logic [31:0] l);
        req_dst[32*i +: 32] = d;
        req_src[32*i +: 32] = s;
        req_len[32*i +: 32] = l;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        cmd_ready = 1'b1;
        cmd_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        cmd_ready = 1'b1;
        cmd_done  = 1'b0;
        req_dst   = '0;
        req_src   = '0;
        req_len   = '0;
        #3;
        total++;
        if ({req_ack, req_done, req_err, cmd_req, busy} !== 14'd0) begin
            bad++;
            $display("FAIL reset_pulses got=%b exp=0", {req_ack, req_done, req_err, cmd_req, busy});
        end
        total++;
        if ({cmd_dst, cmd_src, cmd_len, owner} !== 99'd0) begin
            bad++;
            $display("FAIL reset_regs got dst=%h src=%h len=%h owner=%0d exp all 0",
                     cmd_dst, cmd_src, cmd_len, owner);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_desc(0, 32'h1000, 32'h2000, 32'h100);
        req_valid = 4'b0001;
        step();  // n+1
        total++;
        if (req_ack !== 4'b0001 || cmd_req !== 1'b1 || busy !== 1'b1 || owner !== 3'd0) begin
            bad++;
            $display("FAIL single_ack got ack=%b req=%b busy=%b owner=%0d exp ack=0001 req=1 busy=1 owner=0",
                     req_ack, cmd_req, busy, owner);
        end
        total++;
        if (cmd_dst !== 32'h1000 || cmd_src !== 32'h2000 || cmd_len !== 32'h100) begin
            bad++;
            $display("FAIL single_desc got %h/%h/%h exp 00001000/00002000/00000100",
                     cmd_dst, cmd_src, cmd_len);
        end
        req_valid = 4'b0000;
        set_desc(0, 32'hdead0000, 32'hbeef0000, 32'h55);  // must not disturb the latch
        for (int c = 2; c <= 10; c++) begin
            step();  // n+2 .. n+10
            total++;
            if (cmd_req !== 1'b0 || req_done !== 4'b0000 || req_ack !== 4'b0000 ||
                req_err !== 4'b0000 || busy !== 1'b1) begin
                bad++;
                $display("FAIL single_wait c=%0d got req=%b done=%b ack=%b err=%b busy=%b",
                         c, cmd_req, req_done, req_ack, req_err, busy);
            end
        end
        step();  // n+11: engine completes
        cmd_done = 1'b1;
        step();  // n+12: FIN
        cmd_done = 1'b0;
        total++;
        if (req_done !== 4'b0000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_fin got done=%b busy=%b exp done=0000 busy=1", req_done, busy);
        end
        step();  // n+13
        total++;
        if (req_done !== 4'b0001 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done got done=%b busy=%b exp done=0001 busy=0", req_done, busy);
        end
        total++;
        if (cmd_dst !== 32'h1000 || cmd_len !== 32'h100) begin
            bad++;
            $display("FAIL single_stable got dst=%h len=%h exp 00001000/00000100", cmd_dst, cmd_len);
        end
        step();
        total++;
        if (req_done !== 4'b0000) begin
            bad++;
            $display("FAIL single_done_pulse got=%b exp=0000", req_done);
        end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        int g = 0, dc = 0, last_ack = -1, cyc = 0, last_owner = 0;
        logic pend = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) set_desc(i, 32'h4000 + i, 32'h5000 + i, 32'h40);
        req_valid = 4'b1111;
        while (dc < 6 && cyc < 200) begin
            step();
            cyc++;
            cmd_done = pend;
            pend     = cmd_req;
            if (req_ack !== 4'b0000 && g < 6) begin
                total++;
                if (req_ack !== (4'b0001 << order[g]) || owner !== 3'(order[g])) begin
                    bad++;
                    $display("FAIL rr_grant%0d got ack=%b owner=%0d exp owner=%0d",
                             g, req_ack, owner, order[g]);
                end
                if (last_ack >= 0) begin
                    total++;
                    if (cyc - last_ack !== 4) begin
                        bad++;
                        $display("FAIL rr_spacing got=%0d exp=4", cyc - last_ack);
                    end
                end
                last_ack   = cyc;
                last_owner = order[g];
                g++;
            end
            if (req_done !== 4'b0000) begin
                total++;
                if (req_done !== (4'b0001 << last_owner)) begin
                    bad++;
                    $display("FAIL rr_done%0d got=%b exp owner=%0d", dc, req_done, last_owner);
                end
                dc++;
            end
        end
        total++;
        if (dc != 6 || g != 6) begin
            bad++;
            $display("FAIL rr_budget got grants=%0d dones=%0d exp 6/6", g, dc);
        end
        req_valid = 4'b0000;
        cmd_done  = 1'b0;
    endtask

    task automatic test_zero_len();
        logic saw_req = 1'b0;
        do_reset();
        set_desc(2, 32'h3000, 32'h3100, 32'h0);
        req_valid = 4'b0100;
        step();  // n+1
        saw_req = saw_req | cmd_req;
        total++;
        if (req_ack !== 4'b0100 || owner !== 3'd2 || cmd_len !== 32'h0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_ack got ack=%b owner=%0d len=%h busy=%b exp ack=0100 owner=2 len=0 busy=1",
                     req_ack, owner, cmd_len, busy);
        end
        req_valid = 4'b0000;
        step();  // n+2
        saw_req = saw_req | cmd_req;
        total++;
        if (req_done !== 4'b0100 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_done got done=%b busy=%b exp done=0100 busy=0", req_done, busy);
        end
        step();
        saw_req = saw_req | cmd_req;
        total++;
        if (saw_req !== 1'b0) begin
            bad++;
            $display("FAIL zero_no_cmd got cmd_req seen=%b exp=0", saw_req);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_desc(1, 32'h6000, 32'h7000, 32'h8);
        cmd_ready = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            cmd_done = (c == 2);  // stray completion outside WAIT
            step();
            total++;
            if (req_ack !== 4'b0000 || req_done !== 4'b0000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL stall_c%0d got ack=%b done=%b busy=%b exp 0000/0000/0",
                         c, req_ack, req_done, busy);
            end
        end
        cmd_done  = 1'b0;
        cmd_ready = 1'b1;
        step();
        total++;
        if (req_ack !== 4'b0010 || cmd_dst !== 32'h6000) begin
            bad++;
            $display("FAIL stall_ack got ack=%b dst=%h exp ack=0010 dst=00006000", req_ack, cmd_dst);
        end
        req_valid = 4'b0000;
        step();  // WAIT
        cmd_done = 1'b1;
        step();  // FIN
        cmd_done = 1'b0;
        step();
        total++;
        if (req_done !== 4'b0010) begin
            bad++;
            $display("FAIL stall_done got=%b exp=0010", req_done);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_desc(0, 32'h100, 32'h200, 32'h10);
        set_desc(3, 32'h9000, 32'hA000, 32'h20);
        req_valid = 4'b1000;
        step();
        total++;
        if (req_ack !== 4'b1000 || owner !== 3'd3) begin
            bad++;
            $display("FAIL rstmid_ack got ack=%b owner=%0d exp 1000/3", req_ack, owner);
        end
        step();  // WAIT
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_ack, req_done, req_err, cmd_req, busy, cmd_dst, cmd_src, cmd_len, owner} !== 113'd0) begin
            bad++;
            $display("FAIL rstmid_clear got ack=%b done=%b err=%b req=%b busy=%b dst=%h owner=%0d exp all 0",
                     req_ack, req_done, req_err, cmd_req, busy, cmd_dst, owner);
        end
        step();
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        step();
        total++;
        if (req_done !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_nodone got done=%b busy=%b exp 0000/0", req_done, busy);
        end
        req_valid = 4'b1001;
        step();
        total++;
        if (req_ack !== 4'b0001 || owner !== 3'd0) begin
            bad++;
            $display("FAIL rstmid_next got ack=%b owner=%0d exp 0001/0", req_ack, owner);
        end
        req_valid = 4'b0000;
        step();
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        set_desc(0, 32'hC000, 32'hD000, 32'h80);
        req_valid = 4'b0001;
        step();  // ISSUE entry, n+1
        req_valid = 4'b0000;
`ifdef AQ_MEMCPY_ARB_TIMEOUT_EN
        for (int c = 2; c <= 20; c++) begin
            step();
            total++;
            if (req_err !== 4'b0000 || req_done !== 4'b0000 || busy !== 1'b1) begin
                bad++;
                $display("FAIL tmo_early c=%0d got err=%b done=%b busy=%b", c, req_err, req_done, busy);
            end
        end
        step();  // n+21 = 20 cycles after ISSUE entry
        total++;
        if (req_err !== 4'b0001 || req_done !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL tmo_err got err=%b done=%b busy=%b exp 0001/0000/0", req_err, req_done, busy);
        end
        step();
        total++;
        if (req_err !== 4'b0000 || req_done !== 4'b0000) begin
            bad++;
            $display("FAIL tmo_after got err=%b done=%b exp 0000/0000", req_err, req_done);
        end
`else
        for (int c = 2; c <= 30; c++) begin
            step();
            total++;
            if (req_err !== 4'b0000 || req_done !== 4'b0000 || busy !== 1'b1) begin
                bad++;
                $display("FAIL nowd_wait c=%0d got err=%b done=%b busy=%b", c, req_err, req_done, busy);
            end
        end
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        step();
        total++;
        if (req_done !== 4'b0001 || req_err !== 4'b0000) begin
            bad++;
            $display("FAIL nowd_done got done=%b err=%b exp 0001/0000", req_done, req_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_stall();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
